// File: rtl/tl_responder_pkg.sv
// Shared types for the TileLink manager-side responder: A/D opcodes, grow/cap
// params, FSM states and the line-to-beat helper.
package tl_responder_pkg;

    typedef enum logic [2:0] {
        A_PUT_FULL      = 3'd0,
        A_PUT_PARTIAL   = 3'd1,
        A_ARITHMETIC    = 3'd2,
        A_LOGICAL       = 3'd3,
        A_GET           = 3'd4,
        A_INTENT        = 3'd5,
        A_ACQUIRE_BLOCK = 3'd6,
        A_ACQUIRE_PERM  = 3'd7
    } a_opcode_e;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_GRANT_DATA      = 3'd5
    } d_opcode_e;

    typedef enum logic [2:0] {
        GROW_NTOB = 3'd0,
        GROW_NTOT = 3'd1,
        GROW_BTOT = 3'd2
    } grow_e;

    typedef enum logic [1:0] {
        CAP_TOT = 2'd0,
        CAP_TOB = 2'd1
    } cap_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP,
        ST_GRANT_RD,
        ST_GRANT_D,
        ST_WAIT_E
    } state_e;

    function automatic int unsigned beats_per_line(input int unsigned line_bytes,
                                                   input int unsigned data_w);
        return (line_bytes * 8) / data_w;
    endfunction

endpackage

// File: rtl/tl_resp_beat_counter.sv
// Grant beat index; wrap_o pulses on the increment that rolls the last beat back to 0.
module tl_resp_beat_counter #(
    parameter int unsigned BEATS  = 16,
    parameter int unsigned BEAT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              wrap_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              last;

    always_comb begin
        last   = (beat_q == BEAT_W'(BEATS - 1));
        wrap_o = inc_i && last;
        beat_d = beat_q;
        if (wrap_o) begin
            beat_d = '0;
        end else if (inc_i) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;

endmodule

// File: rtl/tl_acquire_responder.sv
// TileLink manager-side responder between the dcache and a 1-cycle SRAM.
// Optional address window check: define TL_RESPONDER_RANGE_CHECK_EN.
module tl_acquire_responder
    import tl_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SOURCE_W   = 2,
    parameter int unsigned LINE_BYTES = 64
`ifdef TL_RESPONDER_RANGE_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter longint unsigned   SIZE_BYTES = 64'h0001_0000
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [2:0]            a_opcode,
    input  logic [2:0]            a_param,
    input  logic [3:0]            a_size,
    input  logic [SOURCE_W-1:0]   a_source,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic [DATA_W/8-1:0]   a_mask,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  d_valid,
    input  logic                  d_ready,
    output logic [2:0]            d_opcode,
    output logic [1:0]            d_param,
    output logic [3:0]            d_size,
    output logic [SOURCE_W-1:0]   d_source,
    output logic                  d_sink,
    output logic                  d_denied,
    output logic [DATA_W-1:0]     d_data,
    input  logic                  e_valid,
    output logic                  e_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned OFF_W   = $clog2(STRB_W);
    localparam int unsigned LINE_LG = $clog2(LINE_BYTES);
    localparam int unsigned BEATS   = beats_per_line(LINE_BYTES, DATA_W);
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [3:0]          size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [STRB_W-1:0]   mask;
        logic [DATA_W-1:0]   data;
        logic                denied;
    } req_t;

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic              rd_pend_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rd_data;
    logic              a_fire, is_access, is_grant, in_range, a_denied;
    logic              beat_inc, beat_wrap;
    logic [BEAT_W-1:0] beat;

`ifdef TL_RESPONDER_RANGE_CHECK_EN
    localparam int unsigned     AW1      = ADDR_W + 1;
    localparam logic [ADDR_W:0] RANGE_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] RANGE_HI = RANGE_LO + AW1'(SIZE_BYTES);
    assign in_range = ({1'b0, a_address} >= RANGE_LO) && ({1'b0, a_address} < RANGE_HI);
`else
    assign in_range = 1'b1;
`endif

    // A grant needs a full-line size; anything else unsupported becomes a denied AccessAck.
    always_comb begin
        a_fire    = a_valid && a_ready;
        is_access = (a_opcode == A_GET) || (a_opcode == A_PUT_FULL) ||
                    (a_opcode == A_PUT_PARTIAL);
        is_grant  = (a_opcode == A_ACQUIRE_BLOCK) && (a_size == 4'(LINE_LG));
        a_denied  = !(is_access || is_grant) || !in_range;
    end

    // NOTE: every signal driven from always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        req_d = req_q;
        if (a_fire) begin
            req_d.opcode  = a_opcode;
            req_d.param   = a_param;
            req_d.size    = a_size;
            req_d.source  = a_source;
            req_d.address = a_address;
            req_d.mask    = a_mask;
            req_d.data    = a_data;
            req_d.denied  = a_denied;
        end
    end

    // SRAM data is live the cycle after the strobe; hold it so D stays stable under stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= '0;
            rd_pend_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            req_q     <= req_d;
            rd_pend_q <= mem_req && !mem_we;
            if (rd_pend_q) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign rd_data  = rd_pend_q ? mem_rdata : rdata_q;
    assign beat_inc = (state_q == ST_GRANT_D) && d_ready && !req_q.denied;

    tl_resp_beat_counter #(
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) u_beat_counter (
        .clk    (clock),
        .rst_n  (reset_n),
        .inc_i  (beat_inc),
        .beat_o (beat),
        .wrap_o (beat_wrap)
    );

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (a_fire) state_d = is_grant ? ST_GRANT_RD : ST_EXEC;
            ST_EXEC:     state_d = ST_RESP;
            ST_RESP:     if (d_ready) state_d = ST_IDLE;
            ST_GRANT_RD: state_d = ST_GRANT_D;
            ST_GRANT_D:  if (d_ready) state_d = (req_q.denied || beat_wrap) ? ST_WAIT_E : ST_GRANT_RD;
            ST_WAIT_E:   if (e_valid) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_ready   = 1'b0;
        e_ready   = 1'b0;
        d_valid   = 1'b0;
        d_opcode  = D_ACCESS_ACK;
        d_param   = CAP_TOT;
        d_size    = '0;
        d_source  = '0;
        d_sink    = 1'b0;
        d_denied  = 1'b0;
        d_data    = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = req_q.address & ~ADDR_W'(STRB_W - 1);
        mem_wdata = req_q.data;
        mem_wmask = '0;
        case (state_q)
            ST_IDLE: a_ready = 1'b1;
            ST_EXEC: begin
                if (!req_q.denied) begin
                    mem_req = 1'b1;
                    mem_we  = (req_q.opcode != A_GET);
                    if (mem_we) mem_wmask = req_q.mask;
                end
            end
            ST_RESP: begin
                d_valid  = 1'b1;
                d_opcode = (req_q.opcode == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
                d_size   = req_q.size;
                d_source = req_q.source;
                d_denied = req_q.denied;
                if (req_q.opcode == A_GET && !req_q.denied) d_data = rd_data;
            end
            ST_GRANT_RD: begin
                mem_req  = !req_q.denied;
                mem_addr = (req_q.address & ~ADDR_W'(LINE_BYTES - 1)) |
                           (ADDR_W'(beat) << OFF_W);
            end
            ST_GRANT_D: begin
                d_valid  = 1'b1;
                d_opcode = D_GRANT_DATA;
                d_param  = (req_q.param == GROW_NTOB) ? CAP_TOB : CAP_TOT;
                d_size   = req_q.size;
                d_source = req_q.source;
                d_denied = req_q.denied;
                if (!req_q.denied) d_data = rd_data;
            end
            ST_WAIT_E: e_ready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tl_acquire_responder.sv
// Directed bench for tl_acquire_responder with a scoreboard of expected D beats
// and a behavioural 1-cycle SRAM preloaded with word[i] = byte address.
module tb_tl_acquire_responder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [1:0]  d_source;
    logic        d_sink, d_denied;
    logic [31:0] d_data;
    logic        e_valid, e_ready;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int          tests = 0;
    int          fails = 0;
    int          mem_req_cnt = 0;
    logic [44:0] exp_q[$];
    logic [44:0] d_obs;

    assign d_obs = {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data};

    tl_acquire_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_sink    (d_sink),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .e_valid   (e_valid),
        .e_ready   (e_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [0:255];
    logic        ram_init = 1'b0;

    always @(posedge clock) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'(i * 4);
            ram_init <= 1'b1;
        end else if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[9:2]];
            end
        end
    end

    always @(posedge clock) if (mem_req) mem_req_cnt <= mem_req_cnt + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] dbeat(input logic [2:0] op, input logic [1:0] prm,
                                          input logic [3:0] sz, input logic [1:0] src,
                                          input logic den, input logic [31:0] data);
        return {op, prm, sz, src, 1'b0, den, data};
    endfunction

    // Returns just after the A fire edge.
    task automatic send_a(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                          input logic [1:0] src, input logic [31:0] addr,
                          input logic [3:0] msk, input logic [31:0] data);
        int waited;
        waited = 0;
        @(negedge clock);
        a_valid = 1'b1; a_opcode = op; a_param = prm; a_size = sz;
        a_source = src; a_address = addr; a_mask = msk; a_data = data;
        while (!a_ready && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 100) check("a_accept", 64'(a_ready), 64'd1);
        @(posedge clock);
        #1 a_valid = 1'b0;
    endtask

    // Consume nbeats D beats, comparing every cycle d_valid is seen against the queue front.
    task automatic expect_d(input string tag, input int nbeats, input bit toggle,
                            input bit grant, output int lat, output int cyc);
        int got;
        got = 0; lat = 0; cyc = 0;
        for (int k = 1; k <= 400 && got < nbeats; k++) begin
            @(negedge clock);
            if (grant) check({tag, "_a_ready"}, 64'(a_ready), 64'd0);
            d_ready = toggle ? k[1] : 1'b1;
            if (d_valid) begin
                if (lat == 0) lat = k;
                check(tag, 64'(d_obs), (exp_q.size() > 0) ? 64'(exp_q[0]) : 64'hx);
                if (d_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got++;
                    cyc = k;
                end
            end
        end
        check({tag, "_beats"}, 64'(got), 64'(nbeats));
        @(posedge clock);
        #1 d_ready = 1'b0;
    endtask

    task automatic grant_ack(input string tag);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check({tag, "_e_ready"}, 64'(e_ready), 64'd1);
            check({tag, "_a_blocked"}, 64'(a_ready), 64'd0);
        end
        e_valid = 1'b1;
        @(posedge clock);
        #1 e_valid = 1'b0;
        @(negedge clock);
        check({tag, "_a_ready_after_e"}, 64'(a_ready), 64'd1);
        check({tag, "_e_ready_after_e"}, 64'(e_ready), 64'd0);
    endtask

    initial begin
        int lat, cyc, m0, waited;
        a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0;
        a_address = 0; a_mask = 0; a_data = 0; d_ready = 0; e_valid = 0;

        repeat (2) @(negedge clock);
        check("rst_a_ready", 64'(a_ready), 64'd1);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_e_ready", 64'(e_ready), 64'd0);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_d_fields", 64'(d_obs), 64'd0);
        reset_n = 1'b1;

        e_valid = 1'b1;
        @(negedge clock);
        check("idle_e_ignored", 64'(e_ready), 64'd0);
        e_valid = 1'b0;

        // Full put then get.
        m0 = mem_req_cnt;
        exp_q.push_back(dbeat(3'd0, 2'd0, 4'd2, 2'd1, 1'b0, 32'h0));
        send_a(3'd0, 3'd0, 4'd2, 2'd1, 32'h10, 4'hF, 32'hDEADBEEF);
        expect_d("put_full", 1, 1'b0, 1'b0, lat, cyc);
        check("put_full_lat", 64'(lat), 64'd2);
        check("put_full_memreq", 64'(mem_req_cnt - m0), 64'd1);

        exp_q.push_back(dbeat(3'd1, 2'd0, 4'd2, 2'd2, 1'b0, 32'hDEADBEEF));
        send_a(3'd4, 3'd0, 4'd2, 2'd2, 32'h10, 4'h0, 32'h0);
        expect_d("get_full", 1, 1'b0, 1'b0, lat, cyc);
        check("get_full_lat", 64'(lat), 64'd2);

        // Partial put over the low half-word.
        exp_q.push_back(dbeat(3'd0, 2'd0, 4'd2, 2'd1, 1'b0, 32'h0));
        send_a(3'd1, 3'd0, 4'd2, 2'd1, 32'h10, 4'h3, 32'h0000AAAA);
        expect_d("put_partial", 1, 1'b0, 1'b0, lat, cyc);
        exp_q.push_back(dbeat(3'd1, 2'd0, 4'd2, 2'd0, 1'b0, 32'hDEADAAAA));
        send_a(3'd4, 3'd0, 4'd2, 2'd0, 32'h10, 4'h0, 32'h0);
        expect_d("get_partial", 1, 1'b0, 1'b0, lat, cyc);

        // AcquireBlock NtoB, always ready: 2 cycles per beat.
        for (int i = 0; i < 16; i++)
            exp_q.push_back(dbeat(3'd5, 2'd1, 4'd6, 2'd3, 1'b0, 32'(32'h40 + 4 * i)));
        send_a(3'd6, 3'd0, 4'd6, 2'd3, 32'h40, 4'h0, 32'h0);
        expect_d("grant_ntob", 16, 1'b0, 1'b1, lat, cyc);
        check("grant_ntob_lat", 64'(lat), 64'd2);
        check("grant_ntob_cycles", 64'(cyc), 64'd32);
        grant_ack("grant_ntob");

        // AcquireBlock NtoT, unaligned address, d_ready toggling.
        for (int i = 0; i < 16; i++)
            exp_q.push_back(dbeat(3'd5, 2'd0, 4'd6, 2'd2, 1'b0, 32'(32'h40 + 4 * i)));
        send_a(3'd6, 3'd1, 4'd6, 2'd2, 32'h4C, 4'h0, 32'h0);
        expect_d("grant_stall", 16, 1'b1, 1'b1, lat, cyc);
        grant_ack("grant_stall");

        // Refused requests: no SRAM access.
        m0 = mem_req_cnt;
        exp_q.push_back(dbeat(3'd0, 2'd0, 4'd2, 2'd0, 1'b1, 32'h0));
        send_a(3'd2, 3'd0, 4'd2, 2'd0, 32'h10, 4'hF, 32'h1234);
        expect_d("deny_arith", 1, 1'b0, 1'b0, lat, cyc);
        check("deny_arith_lat", 64'(lat), 64'd2);
        exp_q.push_back(dbeat(3'd0, 2'd0, 4'd5, 2'd1, 1'b1, 32'h0));
        send_a(3'd6, 3'd0, 4'd5, 2'd1, 32'h40, 4'h0, 32'h0);
        expect_d("deny_acq_size", 1, 1'b0, 1'b0, lat, cyc);
        check("deny_acq_size_lat", 64'(lat), 64'd2);
        exp_q.push_back(dbeat(3'd0, 2'd0, 4'd6, 2'd2, 1'b1, 32'h0));
        send_a(3'd7, 3'd0, 4'd6, 2'd2, 32'h40, 4'h0, 32'h0);
        expect_d("deny_op7", 1, 1'b0, 1'b0, lat, cyc);
        check("deny_memreq", 64'(mem_req_cnt - m0), 64'd0);

        // Reset in the middle of a grant, while beat 5 is stalled.
        for (int i = 0; i < 16; i++)
            exp_q.push_back(dbeat(3'd5, 2'd0, 4'd6, 2'd1, 1'b0, 32'(32'h80 + 4 * i)));
        send_a(3'd6, 3'd1, 4'd6, 2'd1, 32'h80, 4'h0, 32'h0);
        expect_d("grant_pre_rst", 5, 1'b0, 1'b1, lat, cyc);
        waited = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!d_valid && waited < 10);
        check("rst_beat5", 64'(d_obs), 64'(exp_q[0]));
        reset_n = 1'b0;
        #1;
        check("midrst_d_valid", 64'(d_valid), 64'd0);
        check("midrst_d_fields", 64'(d_obs), 64'd0);
        check("midrst_a_ready", 64'(a_ready), 64'd1);
        check("midrst_e_ready", 64'(e_ready), 64'd0);
        check("midrst_mem_req", 64'(mem_req), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;

        exp_q.push_back(dbeat(3'd1, 2'd0, 4'd2, 2'd3, 1'b0, 32'hDEADAAAA));
        send_a(3'd4, 3'd0, 4'd2, 2'd3, 32'h10, 4'h0, 32'h0);
        expect_d("get_after_rst", 1, 1'b0, 1'b0, lat, cyc);
        check("get_after_rst_lat", 64'(lat), 64'd2);

        for (int i = 0; i < 16; i++)
            exp_q.push_back(dbeat(3'd5, 2'd1, 4'd6, 2'd0, 1'b0, 32'(32'h80 + 4 * i)));
        send_a(3'd6, 3'd0, 4'd6, 2'd0, 32'h80, 4'h0, 32'h0);
        expect_d("grant_after_rst", 16, 1'b0, 1'b1, lat, cyc);
        grant_ack("grant_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
